// File: rtl/max7219_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : max7219_pkg                                               |
// | Purpose  : Shared constants and types for the MAX7219 receiver:      |
// |            frame width, register address map, receiver FSM states.  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package max7219_pkg;

  localparam int FRAME_W = 16;

  localparam logic [3:0] ADDR_NOOP      = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
  localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
  localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
  localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
  localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
  localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
  localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
  localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
  localparam logic [3:0] ADDR_DECODE    = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCANLIMIT = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] ADDR_TEST      = 4'hF;

  // IDLE: CS high. SHIFT: CS low and armed by a seen falling edge.
  // DISARMED: CS low without a seen falling edge (e.g. reset mid-frame).
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT    = 2'd1,
    ST_DISARMED = 2'd2
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/max7219_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : max7219_if                                                |
// | Purpose  : MAX7219 serial link bundle.                               |
// |   CS   - chip select, active low (driver -> receiver)                |
// |   CLK  - serial clock, data sampled on rising edge                   |
// |   Din  - serial data, MSB first                                      |
// |   Dout - daisy-chain output (receiver -> next stage)                 |
// |   master: the serial driver side; slave: the receiver side.          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface max7219_if;
  logic CS;
  logic CLK;
  logic Din;
  logic Dout;

  modport master (output CS, output CLK, output Din, input Dout);
  modport slave  (input CS, input CLK, input Din, output Dout);
endinterface
`default_nettype wire

// File: rtl/max7219_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sync_edge                                                 |
// | Purpose  : STAGES-deep synchronizer with a previous-value flop that  |
// |            produces single-cycle rise/fall pulses.                   |
// |   clk, rst - system clock, async active-high reset                   |
// |   i_d      - asynchronous input                                      |
// |   o_q      - synchronized level                                      |
// |   o_rise   - one-cycle pulse on a synchronized 0->1                  |
// |   o_fall   - one-cycle pulse on a synchronized 1->0                  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module sync_edge #(
  parameter int STAGES = 2
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_d,
  output logic      o_q,
  output logic      o_rise,
  output logic      o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_rise =  r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] &  r_prev;

endmodule
`default_nettype wire

// File: rtl/max7219_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : max7219_receiver                                          |
// | Purpose  : Receiving end of the MAX7219 serial link. Oversamples the |
// |            link with sys_clk, assembles 16-bit frames and mirrors    |
// |            the MAX7219 register file.                                |
// |   sys_clk, rst   - system clock, async active-high reset             |
// |   bus (slave)    - CS/CLK/Din in, Dout daisy-chain out               |
// |   rows           - 8 digit registers, digit k at [8k+7:8k]           |
// |   decode_mode, intensity, scan_limit, shutdown_n, display_test       |
// |   frame_valid    - one-cycle strobe per latched frame                |
// |   frame_addr/data- address/data of the last latched frame            |
// |   frame_err      - one-cycle strobe on a short frame                 |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module max7219_receiver
  import max7219_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  wire logic  sys_clk,
  input  wire logic  rst,
  max7219_if.slave   bus,
  output logic [63:0] rows,
  output logic [7:0]  decode_mode,
  output logic [3:0]  intensity,
  output logic [2:0]  scan_limit,
  output logic        shutdown_n,
  output logic        display_test,
  output logic        frame_valid,
  output logic [3:0]  frame_addr,
  output logic [7:0]  frame_data,
  output logic        frame_err
);

  logic w_cs_q, w_cs_rise, w_cs_fall;
  logic w_clk_q_unused, w_clk_rise, w_clk_fall;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk    (sys_clk),
    .rst    (rst),
    .i_d    (bus.CS),
    .o_q    (w_cs_q),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk    (sys_clk),
    .rst    (rst),
    .i_d    (bus.CLK),
    .o_q    (w_clk_q_unused),
    .o_rise (w_clk_rise),
    .o_fall (w_clk_fall)
  );

  // Din goes through the same depth as CLK so the sampled bit lines up
  // with the detected CLK rising edge.
  logic [SYNC_STAGES-1:0] r_din_sync;
  logic                   w_din;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) r_din_sync <= '0;
    else     r_din_sync <= {r_din_sync[SYNC_STAGES-2:0], bus.Din};
  end

  assign w_din = r_din_sync[SYNC_STAGES-1];

  rx_state_t          r_state;
  logic [FRAME_W-1:0] r_shreg;
  logic [4:0]         r_bitcnt;
  logic               r_dout;
  logic [63:0]        r_rows;
  logic [7:0]         r_decode;
  logic [3:0]         r_intensity;
  logic [2:0]         r_scan;
  logic               r_shutdown_n;
  logic               r_test;
  logic               r_fvalid;
  logic               r_ferr;
  logic [3:0]         r_faddr;
  logic [7:0]         r_fdata;

  logic [3:0] w_addr;
  logic [7:0] w_data;
  logic [3:0] w_addr_m1;
  logic [2:0] w_digit;
  logic       w_clk_accept;

  assign w_addr       = r_shreg[11:8];
  assign w_data       = r_shreg[7:0];
  assign w_addr_m1    = w_addr - 4'd1;
  assign w_digit      = w_addr_m1[2:0];
  // CS rising shows up as w_cs_q = 1, so a coincident CLK edge is dropped.
  assign w_clk_accept = w_clk_rise & ~w_cs_q;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_DISARMED;
      r_shreg      <= '0;
      r_bitcnt     <= '0;
      r_dout       <= 1'b0;
      r_rows       <= '0;
      r_decode     <= '0;
      r_intensity  <= '0;
      r_scan       <= '0;
      r_shutdown_n <= 1'b0;
      r_test       <= 1'b0;
      r_fvalid     <= 1'b0;
      r_ferr       <= 1'b0;
      r_faddr      <= '0;
      r_fdata      <= '0;
    end else begin
      r_fvalid <= 1'b0;
      r_ferr   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_state  <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (w_clk_fall) r_dout <= r_shreg[FRAME_W-1];
          if (w_cs_rise) begin
            r_state <= ST_IDLE;
            if (r_bitcnt == 5'(FRAME_W)) begin
              r_fvalid <= 1'b1;
              r_faddr  <= w_addr;
              r_fdata  <= w_data;
              case (w_addr)
                ADDR_DIGIT0, ADDR_DIGIT1, ADDR_DIGIT2, ADDR_DIGIT3,
                ADDR_DIGIT4, ADDR_DIGIT5, ADDR_DIGIT6, ADDR_DIGIT7:
                  r_rows[{w_digit, 3'b000} +: 8] <= w_data;
                ADDR_DECODE:    r_decode     <= w_data;
                ADDR_INTENSITY: r_intensity  <= w_data[3:0];
                ADDR_SCANLIMIT: r_scan       <= w_data[2:0];
                ADDR_SHUTDOWN:  r_shutdown_n <= w_data[0];
                ADDR_TEST:      r_test       <= w_data[0];
                default: ;  // no-op and the unused 0xD/0xE
              endcase
            end else begin
              r_ferr <= 1'b1;
            end
          end else if (w_clk_accept) begin
            // Over-long frames keep only the newest 16 bits.
            r_shreg <= {r_shreg[FRAME_W-2:0], w_din};
            if (r_bitcnt != 5'(FRAME_W)) r_bitcnt <= r_bitcnt + 5'd1;
          end
        end

        ST_DISARMED: begin
          if (w_cs_q) r_state <= ST_IDLE;
        end

        default: r_state <= ST_DISARMED;
      endcase
    end
  end

  assign bus.Dout     = r_dout;
  assign rows         = r_rows;
  assign decode_mode  = r_decode;
  assign intensity    = r_intensity;
  assign scan_limit   = r_scan;
  assign shutdown_n   = r_shutdown_n;
  assign display_test = r_test;
  assign frame_valid  = r_fvalid;
  assign frame_err    = r_ferr;
  assign frame_addr   = r_faddr;
  assign frame_data   = r_fdata;

endmodule
`default_nettype wire

// File: tb/tb_max7219_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_max7219_receiver                                       |
// | Purpose  : Directed scoreboard bench for max7219_receiver. Stimulus  |
// |            queues the expected frame strobe; a monitor compares it   |
// |            whenever frame_valid/frame_err fires.                     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_max7219_receiver;

  logic        sys_clk;
  logic        rst;
  logic [63:0] rows;
  logic [7:0]  decode_mode;
  logic [3:0]  intensity;
  logic [2:0]  scan_limit;
  logic        shutdown_n;
  logic        display_test;
  logic        frame_valid;
  logic [3:0]  frame_addr;
  logic [7:0]  frame_data;
  logic        frame_err;

  max7219_if bus ();

  max7219_receiver #(.SYNC_STAGES(2)) dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .bus          (bus),
    .rows         (rows),
    .decode_mode  (decode_mode),
    .intensity    (intensity),
    .scan_limit   (scan_limit),
    .shutdown_n   (shutdown_n),
    .display_test (display_test),
    .frame_valid  (frame_valid),
    .frame_addr   (frame_addr),
    .frame_data   (frame_data),
    .frame_err    (frame_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       is_err;
    logic [3:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_fv  = 0;
  bit          dout_chk = 1'b0;
  logic [31:0] dout_stream = '0;

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic cs_low();
    bus.CS = 1'b0;
    wait_cyc(6);
  endtask

  // kind: 0 = no strobe expected, 1 = frame_valid, 2 = frame_err
  task automatic cs_high(input int kind, input logic [3:0] a, input logic [7:0] d);
    exp_t e;
    if (kind != 0) begin
      e.is_err = (kind == 2);
      e.addr   = a;
      e.data   = d;
      sb_q.push_back(e);
    end
    bus.CS = 1'b1;
    wait_cyc(10);
  endtask

  // Shift the low n bits of d, MSB first, at sys_clk/24.
  task automatic clock_bits(input logic [31:0] d, input int n);
    logic exp_dout;
    for (int i = n - 1; i >= 0; i--) begin
      bus.Din = d[i];
      wait_cyc(6);
      bus.CLK = 1'b1;
      wait_cyc(12);
      bus.CLK = 1'b0;
      wait_cyc(6);
      if (dout_chk) begin
        // After falling edge k, Dout is stream bit (k-16) from the MSB.
        int k;
        k = n - i;
        exp_dout = (k >= 16) ? dout_stream[47 - k] : 1'b0;
        chk($sformatf("dout_k%0d", k), {63'd0, bus.Dout}, {63'd0, exp_dout});
      end
    end
  endtask

  task automatic frame16(input logic [15:0] f, input int kind, input logic [3:0] a, input logic [7:0] d);
    cs_low();
    clock_bits({16'd0, f}, 16);
    cs_high(kind, a, d);
  endtask

  // Scoreboard monitor.
  always @(negedge sys_clk) begin
    if (!rst && (frame_valid || frame_err)) begin
      exp_t e;
      n_vec++;
      if (frame_valid) n_fv++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: valid=%b err=%b addr=%h data=%h, expected no strobe",
                 frame_valid, frame_err, frame_addr, frame_data);
      end else begin
        e = sb_q.pop_front();
        if (frame_err !== e.is_err || frame_valid !== !e.is_err ||
            frame_addr !== e.addr || frame_data !== e.data) begin
          n_err++;
          $display("FAIL strobe: got valid=%b err=%b addr=%h data=%h, expected valid=%b err=%b addr=%h data=%h",
                   frame_valid, frame_err, frame_addr, frame_data,
                   !e.is_err, e.is_err, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    repeat (60000) @(posedge sys_clk);
    $display("FAIL watchdog: simulation did not finish within cycle budget");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rows"},   rows,                  64'd0);
    chk({tag, "_decode"}, {56'd0, decode_mode},  64'd0);
    chk({tag, "_inten"},  {60'd0, intensity},    64'd0);
    chk({tag, "_scan"},   {61'd0, scan_limit},   64'd0);
    chk({tag, "_shdn"},   {63'd0, shutdown_n},   64'd0);
    chk({tag, "_test"},   {63'd0, display_test}, 64'd0);
    chk({tag, "_dout"},   {63'd0, bus.Dout},     64'd0);
    chk({tag, "_faddr"},  {60'd0, frame_addr},   64'd0);
    chk({tag, "_fdata"},  {56'd0, frame_data},   64'd0);
    chk({tag, "_strobe"}, {62'd0, frame_valid, frame_err}, 64'd0);
  endtask

  initial begin
    int fv_snap;
    rst     = 1'b1;
    bus.CS  = 1'b1;
    bus.CLK = 1'b0;
    bus.Din = 1'b0;
    wait_cyc(5);
    chk_reset_state("rst");
    rst = 1'b0;
    wait_cyc(10);

    // Init sequence plus a pet bitmap.
    frame16(16'h0C01, 1, 4'hC, 8'h01);
    frame16(16'h0900, 1, 4'h9, 8'h00);
    frame16(16'h0A00, 1, 4'hA, 8'h00);
    frame16(16'h0B07, 1, 4'hB, 8'h07);
    frame16(16'h013C, 1, 4'h1, 8'h3C);
    frame16(16'h027E, 1, 4'h2, 8'h7E);
    frame16(16'h03DB, 1, 4'h3, 8'hDB);
    frame16(16'h04FF, 1, 4'h4, 8'hFF);
    frame16(16'h05FF, 1, 4'h5, 8'hFF);
    frame16(16'h06DB, 1, 4'h6, 8'hDB);
    frame16(16'h0766, 1, 4'h7, 8'h66);
    frame16(16'h083C, 1, 4'h8, 8'h3C);
    chk("init_shdn",   {63'd0, shutdown_n},  64'd1);
    chk("init_scan",   {61'd0, scan_limit},  64'd7);
    chk("init_inten",  {60'd0, intensity},   64'd0);
    chk("init_decode", {56'd0, decode_mode}, 64'd0);
    chk("init_rows",   rows, 64'h3C66_DBFF_FFDB_7E3C);
    chk("init_fv_cnt", 64'(n_fv), 64'd12);

    // Short frame: 12 bits only.
    cs_low();
    clock_bits(32'h0000_00C1, 12);
    cs_high(2, 4'h8, 8'h3C);
    chk("short_shdn",  {63'd0, shutdown_n}, 64'd1);
    chk("short_faddr", {60'd0, frame_addr}, 64'd8);
    chk("short_rows",  rows, 64'h3C66_DBFF_FFDB_7E3C);

    // 32-bit burst under one CS: only the last 16 bits take effect.
    dout_stream = 32'h0A05_0103;
    dout_chk    = 1'b1;
    cs_low();
    clock_bits(32'h0A05_0103, 32);
    dout_chk    = 1'b0;
    cs_high(1, 4'h1, 8'h03);
    chk("burst_rows",  rows, 64'h3C66_DBFF_FFDB_7E03);
    chk("burst_inten", {60'd0, intensity}, 64'd0);

    // Display test on, then off via an address with a junk upper nibble.
    frame16(16'h0F01, 1, 4'hF, 8'h01);
    chk("test_on",  {63'd0, display_test}, 64'd1);
    frame16(16'hFF00, 1, 4'hF, 8'h00);
    chk("test_off", {63'd0, display_test}, 64'd0);

    // Reset mid-frame, released with CS low; the tail must be discarded.
    fv_snap = n_fv;
    cs_low();
    clock_bits(32'h0000_000C, 8);
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(4);
    clock_bits(32'h0000_0001, 8);
    cs_high(0, 4'h0, 8'h00);
    chk_reset_state("midrst");
    chk("midrst_no_fv", 64'(n_fv), 64'(fv_snap));
    frame16(16'h0C01, 1, 4'hC, 8'h01);
    chk("midrst_shdn", {63'd0, shutdown_n}, 64'd1);

    // No-op frame: strobe only.
    frame16(16'h0055, 1, 4'h0, 8'h55);
    chk("noop_rows",  rows, 64'd0);
    chk("noop_shdn",  {63'd0, shutdown_n},   64'd1);
    chk("noop_test",  {63'd0, display_test}, 64'd0);
    chk("noop_faddr", {60'd0, frame_addr},   64'd0);
    chk("noop_fdata", {56'd0, frame_data},   64'd55 + 64'd30);

    wait_cyc(10);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
